// File: rtl/cpu_defs.sv
// cpu_defs: opcodes, FSM state encoding and datapath select codes for the multi-cycle controller
package cpu_defs;
  localparam logic [5:0] OP_R = 6'd0, OP_J = 6'd2, OP_JAL = 6'd3, OP_BNE = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8, OP_XORI = 6'd14, OP_LW = 6'd35, OP_SW = 6'd43;
  localparam logic [5:0] F_JR = 6'd8, F_ADD = 6'd32, F_SUB = 6'd34, F_SLT = 6'd42;
  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_HALT
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2, ALU_SLT = 3'd3;
  localparam logic [1:0] PC_INC = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2, PC_RS = 2'd3;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
  localparam logic [1:0] RS_ALU = 2'd0, RS_MEM = 2'd1, RS_PC = 2'd2;
  localparam logic [1:0] B_RT = 2'd0, B_SIMM = 2'd1, B_ZIMM = 2'd2;
  function automatic logic [2:0] alu_of_funct(input logic [5:0] funct);
    return funct == F_SUB ? ALU_SUB : funct == F_SLT ? ALU_SLT : ALU_ADD;
  endfunction
endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: decoder/memory status inputs and datapath control outputs of the controller
interface mc_controller_if;
  logic [5:0] op, funct;
  logic alu_zero, mem_ready;
  logic ir_we, pc_we, mem_req, mem_we, mem_addr_sel, reg_we, instr_done, illegal, bus_err;
  logic [1:0] pc_src, reg_dst, reg_src, alu_src_b;
  logic [2:0] alu_op;
  modport slave (
    input op, funct, alu_zero, mem_ready,
    output ir_we, pc_we, pc_src, mem_req, mem_we, mem_addr_sel, reg_we, reg_dst, reg_src,
    alu_src_b, alu_op, instr_done, illegal, bus_err
  );
  modport master (
    output op, funct, alu_zero, mem_ready,
    input ir_we, pc_we, pc_src, mem_req, mem_we, mem_addr_sel, reg_we, reg_dst, reg_src,
    alu_src_b, alu_op, instr_done, illegal, bus_err
  );
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts un-acked memory cycles; expired flags the WAIT_LIMIT-th waiting cycle
module mem_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  assign expired = en && cnt == 8'(WAIT_LIMIT - 1);
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle fetch/decode/execute/memory/writeback control FSM for the lab CPU
module mc_controller
  import cpu_defs::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input logic clk,
  input logic reset,
  mc_controller_if.slave bus
);
  state_t state, nxt;
  logic illegal_q, bus_err_q, in_wait, expired;
  logic [5:0] op, funct;
  assign op = bus.op;
  assign funct = bus.funct;
  assign in_wait = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clk(clk), .reset(reset), .clr(!in_wait || bus.mem_ready),
    .en(in_wait && !bus.mem_ready), .expired(expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_RST;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= nxt;
      illegal_q <= illegal_q || (state == S_DECODE && nxt == S_HALT);
      bus_err_q <= bus_err_q || expired;
    end
  always_comb begin
    nxt = state;
    case (state)
      S_RST:      nxt = S_FETCH;
      S_FETCH:    nxt = bus.mem_ready ? S_DECODE : expired ? S_HALT : S_FETCH;
      S_DECODE:   nxt = op == OP_R ? (funct inside {F_ADD, F_SUB, F_SLT} ? S_EXEC_R :
                                      funct == F_JR ? S_JR : S_HALT) :
                        op inside {OP_ADDI, OP_XORI} ? S_EXEC_I :
                        op inside {OP_LW, OP_SW}     ? S_MEM_ADDR :
                        op == OP_BNE                 ? S_BRANCH :
                        op inside {OP_J, OP_JAL}     ? S_JUMP : S_HALT;
      S_EXEC_R:   nxt = S_WB_R;
      S_EXEC_I:   nxt = S_WB_I;
      S_MEM_ADDR: nxt = op == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = bus.mem_ready ? S_MEM_WB : expired ? S_HALT : S_MEM_RD;
      S_MEM_WR:   nxt = bus.mem_ready ? S_FETCH : expired ? S_HALT : S_MEM_WR;
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP, S_JR: nxt = S_FETCH;
      default:    nxt = state;
    endcase
  end
  always_comb begin
    bus.ir_we = 1'b0;
    bus.pc_we = 1'b0;
    bus.pc_src = PC_INC;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.reg_we = 1'b0;
    bus.reg_dst = RD_RT;
    bus.reg_src = RS_ALU;
    bus.alu_src_b = B_RT;
    bus.alu_op = ALU_ADD;
    bus.instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.ir_we = bus.mem_ready;
        bus.pc_we = bus.mem_ready;
      end
      S_EXEC_R, S_WB_R: begin
        bus.alu_op = alu_of_funct(funct);
        bus.reg_we = state == S_WB_R;
        bus.reg_dst = state == S_WB_R ? RD_RD : RD_RT;
        bus.instr_done = state == S_WB_R;
      end
      S_EXEC_I, S_WB_I: begin
        bus.alu_src_b = op == OP_XORI ? B_ZIMM : B_SIMM;
        bus.alu_op = op == OP_XORI ? ALU_XOR : ALU_ADD;
        bus.reg_we = state == S_WB_I;
        bus.instr_done = state == S_WB_I;
      end
      // address computation stays on the ALU while the memory request is outstanding
      S_MEM_ADDR, S_MEM_RD, S_MEM_WR: begin
        bus.alu_src_b = B_SIMM;
        bus.mem_req = state != S_MEM_ADDR;
        bus.mem_addr_sel = state != S_MEM_ADDR;
        bus.mem_we = state == S_MEM_WR;
        bus.instr_done = state == S_MEM_WR && bus.mem_ready;
      end
      S_MEM_WB: begin
        bus.reg_we = 1'b1;
        bus.reg_src = RS_MEM;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_op = ALU_SUB;
        bus.pc_we = !bus.alu_zero;
        bus.pc_src = bus.alu_zero ? PC_INC : PC_BR;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_we = 1'b1;
        bus.pc_src = PC_JMP;
        bus.reg_we = op == OP_JAL;
        bus.reg_dst = op == OP_JAL ? RD_RA : RD_RT;
        bus.reg_src = op == OP_JAL ? RS_PC : RS_ALU;
        bus.instr_done = 1'b1;
      end
      S_JR: begin
        bus.pc_we = 1'b1;
        bus.pc_src = PC_RS;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end
  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: table-driven cycle-by-cycle check of mc_controller control outputs
module tb_mc_controller;
  typedef struct {
    logic rst;
    logic [5:0] op, funct;
    logic z, rdy;
    logic [17:0] ctl;
    logic ill, be;
    string name;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;
  vec_t tbl[$];
  mc_controller_if bus();
  mc_controller #(.WAIT_LIMIT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [17:0] c(input logic ir, pc, input logic [1:0] pcs,
                                    input logic mr, mw, mas, rw,
                                    input logic [1:0] rd, rs, asb,
                                    input logic [2:0] aop, input logic d);
    return {ir, pc, pcs, mr, mw, mas, rw, rd, rs, asb, aop, d};
  endfunction
  task automatic add(input logic rst, input logic [5:0] op, funct, input logic z, rdy,
                     input logic [17:0] ctl, input logic ill, be, input string name);
    vec_t v;
    v = '{rst, op, funct, z, rdy, ctl, ill, be, name};
    tbl.push_back(v);
  endtask
  task automatic fd(input logic [5:0] op, funct, input string n);
    add(0, op, funct, 0, 1, c(1,1,0,1,0,0,0,0,0,0,0,0), 0, 0, {n, "_fetch"});
    add(0, op, funct, 0, 0, '0, 0, 0, {n, "_decode"});
  endtask
  task automatic step(input logic rst, input logic [5:0] op, funct, input logic z, rdy,
                      input logic [17:0] ctl, input logic ill, be, input string name);
    logic [19:0] got, exp;
    @(negedge clk);
    reset = rst;
    bus.op = op;
    bus.funct = funct;
    bus.alu_zero = z;
    bus.mem_ready = rdy;
    #2;
    got = {bus.ir_we, bus.pc_we, bus.pc_src, bus.mem_req, bus.mem_we, bus.mem_addr_sel,
           bus.reg_we, bus.reg_dst, bus.reg_src, bus.alu_src_b, bus.alu_op, bus.instr_done,
           bus.illegal, bus.bus_err};
    exp = {ctl, ill, be};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", name, got, exp);
    end
  endtask
  initial begin
    logic [17:0] fa, mr;
    fa = c(1,1,0,1,0,0,0,0,0,0,0,0);
    mr = c(0,0,0,1,0,0,0,0,0,0,0,0);
    bus.op = '0;
    bus.funct = '0;
    bus.alu_zero = 1'b0;
    bus.mem_ready = 1'b0;
    add(1, 0, 0, 0, 0, '0, 0, 0, "reset");
    add(0, 0, 0, 0, 0, '0, 0, 0, "rst_release");
    fd(0, 32, "add");
    add(0, 0, 32, 0, 0, c(0,0,0,0,0,0,0,0,0,0,0,0), 0, 0, "add_exec");
    add(0, 0, 32, 0, 0, c(0,0,0,0,0,0,1,1,0,0,0,1), 0, 0, "add_wb");
    fd(0, 34, "sub");
    add(0, 0, 34, 0, 0, c(0,0,0,0,0,0,0,0,0,0,1,0), 0, 0, "sub_exec");
    add(0, 0, 34, 0, 0, c(0,0,0,0,0,0,1,1,0,0,1,1), 0, 0, "sub_wb");
    fd(0, 42, "slt");
    add(0, 0, 42, 0, 0, c(0,0,0,0,0,0,0,0,0,0,3,0), 0, 0, "slt_exec");
    add(0, 0, 42, 0, 0, c(0,0,0,0,0,0,1,1,0,0,3,1), 0, 0, "slt_wb");
    fd(35, 0, "lw");
    add(0, 35, 0, 0, 0, c(0,0,0,0,0,0,0,0,0,1,0,0), 0, 0, "lw_addr");
    for (int i = 0; i < 3; i++)
      add(0, 35, 0, 0, 0, c(0,0,0,1,0,1,0,0,0,1,0,0), 0, 0, "lw_wait");
    add(0, 35, 0, 0, 1, c(0,0,0,1,0,1,0,0,0,1,0,0), 0, 0, "lw_ack");
    add(0, 35, 0, 0, 0, c(0,0,0,0,0,0,1,0,1,0,0,1), 0, 0, "lw_wb");
    fd(43, 0, "sw");
    add(0, 43, 0, 0, 0, c(0,0,0,0,0,0,0,0,0,1,0,0), 0, 0, "sw_addr");
    add(0, 43, 0, 0, 0, c(0,0,0,1,1,1,0,0,0,1,0,0), 0, 0, "sw_wait");
    add(0, 43, 0, 0, 1, c(0,0,0,1,1,1,0,0,0,1,0,1), 0, 0, "sw_ack");
    fd(5, 0, "bne_taken");
    add(0, 5, 0, 0, 0, c(0,1,1,0,0,0,0,0,0,0,1,1), 0, 0, "bne_taken_br");
    fd(5, 0, "bne_not");
    add(0, 5, 0, 1, 0, c(0,0,0,0,0,0,0,0,0,0,1,1), 0, 0, "bne_not_br");
    fd(8, 0, "addi");
    add(0, 8, 0, 0, 0, c(0,0,0,0,0,0,0,0,0,1,0,0), 0, 0, "addi_exec");
    add(0, 8, 0, 0, 0, c(0,0,0,0,0,0,1,0,0,1,0,1), 0, 0, "addi_wb");
    fd(14, 0, "xori");
    add(0, 14, 0, 0, 0, c(0,0,0,0,0,0,0,0,0,2,2,0), 0, 0, "xori_exec");
    add(0, 14, 0, 0, 0, c(0,0,0,0,0,0,1,0,0,2,2,1), 0, 0, "xori_wb");
    fd(3, 0, "jal");
    add(0, 3, 0, 0, 0, c(0,1,2,0,0,0,1,2,2,0,0,1), 0, 0, "jal_jump");
    fd(2, 0, "j");
    add(0, 2, 0, 0, 0, c(0,1,2,0,0,0,0,0,0,0,0,1), 0, 0, "j_jump");
    fd(0, 8, "jr");
    add(0, 0, 8, 0, 0, c(0,1,3,0,0,0,0,0,0,0,0,1), 0, 0, "jr_jump");
    fd(0, 32, "midrst");
    add(0, 0, 32, 0, 0, '0, 0, 0, "midrst_exec");
    add(1, 0, 32, 0, 0, '0, 0, 0, "midrst_abandon");
    add(0, 0, 32, 0, 0, '0, 0, 0, "midrst_release");
    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].op, tbl[i].funct, tbl[i].z, tbl[i].rdy,
           tbl[i].ctl, tbl[i].ill, tbl[i].be, tbl[i].name);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, mr, 0, 0, "fetch_wait");
    for (int i = 0; i < 3; i++) step(0, 0, 32, 0, 1, '0, 0, 1, "timeout_halt");
    step(1, 0, 0, 0, 0, '0, 0, 0, "rst_clears_bus_err");
    step(0, 0, 0, 0, 0, '0, 0, 0, "rst_release2");
    for (int i = 0; i < 3; i++) step(0, 63, 0, 0, 0, mr, 0, 0, "fetch_wait_limit");
    step(0, 63, 0, 0, 1, fa, 0, 0, "ack_at_limit");
    step(0, 63, 0, 0, 0, '0, 0, 0, "illegal_decode");
    for (int i = 0; i < 20; i++) step(0, 63, 0, 0, 1, '0, 1, 0, "illegal_halt");
    step(1, 63, 0, 0, 0, '0, 0, 0, "rst_clears_illegal");
    step(0, 0, 0, 0, 0, '0, 0, 0, "rst_release3");
    step(0, 0, 0, 0, 0, mr, 0, 0, "fetch_after_rst");
    step(0, 0, 0, 0, 1, fa, 0, 0, "badfunct_fetch");
    step(0, 0, 0, 0, 0, '0, 0, 0, "badfunct_decode");
    step(0, 0, 0, 0, 0, '0, 1, 0, "badfunct_halt");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
